// File: rtl/pcap_stim_gen.sv
// Position-capture TTL stimulus generator: optional pre-delay, then framed trains of
// capture pulses inside an enable window, with gaps, repeats, abort and config checking.
module pcap_stim_gen #(
    parameter int NUM_TTL = 6,
    parameter int EN_BIT  = 0,
    parameter int CAP_BIT = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               arm_i,
    input  logic               disarm_i,
    input  logic [CNT_W-1:0]   pre_delay_i,
    input  logic [CNT_W-1:0]   num_samples_i,
    input  logic [CNT_W-1:0]   cap_period_i,
    input  logic [CNT_W-1:0]   cap_width_i,
    input  logic [CNT_W-1:0]   repeats_i,
    input  logic [NUM_TTL-1:0] ttl_i,
    output logic [NUM_TTL-1:0] ttl_o,
    output logic               active_o,
    output logic               done_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   sample_count_o,
    output logic [CNT_W-1:0]   frame_count_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    typedef enum logic [1:0] {IDLE, DELAY, FRAME, GAP} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [CNT_W-1:0]   smp, smp_nx;
    logic [CNT_W-1:0]   samples_nx, frames_nx;
    logic [CNT_W-1:0]   pre_delay, num_samples, cap_period, cap_width, repeats;
    logic               en, cap, en_nx, cap_nx;
    logic               active_nx, done_nx, err_nx;
    logic               load, cfg_ok, abort_q;
    logic [NUM_TTL-1:0] ttl_nx;

    assign en  = ttl_o[EN_BIT];
    assign cap = ttl_o[CAP_BIT];

    always_comb begin
        cfg_ok = (num_samples_i != '0) && (cap_period_i >= TWO) &&
                 (cap_width_i != '0) && (cap_width_i < cap_period_i);
        state_nx   = state;
        cnt_nx     = cnt;
        smp_nx     = smp;
        samples_nx = sample_count_o;
        frames_nx  = frame_count_o;
        en_nx      = en;
        cap_nx     = cap;
        active_nx  = active_o;
        done_nx    = 1'b0;
        err_nx     = err_o;
        load       = 1'b0;

        unique case (state)
            IDLE: begin
                en_nx     = 1'b0;
                cap_nx    = 1'b0;
                active_nx = 1'b0;
                if (arm_i && !disarm_i) begin
                    if (cfg_ok) begin
                        load       = 1'b1;
                        err_nx     = 1'b0;
                        samples_nx = '0;
                        frames_nx  = '0;
                        cnt_nx     = '0;
                        state_nx   = DELAY;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            DELAY: begin
                active_nx = 1'b1;
                if (cnt == pre_delay) begin
                    state_nx   = FRAME;
                    en_nx      = 1'b1;
                    cap_nx     = 1'b1;
                    cnt_nx     = '0;
                    smp_nx     = '0;
                    samples_nx = sample_count_o + ONE;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            FRAME: begin
                // cnt is the phase within the current capture period
                if (cnt == cap_period - ONE) begin
                    cnt_nx = '0;
                    if (smp == num_samples - ONE) begin
                        en_nx     = 1'b0;
                        cap_nx    = 1'b0;
                        frames_nx = frame_count_o + ONE;
                        if ((repeats != '0) && (frames_nx == repeats)) begin
                            state_nx  = IDLE;
                            active_nx = 1'b0;
                            done_nx   = 1'b1;
                        end else begin
                            state_nx = GAP;
                        end
                    end else begin
                        smp_nx     = smp + ONE;
                        cap_nx     = 1'b1;
                        samples_nx = sample_count_o + ONE;
                    end
                end else begin
                    cnt_nx = cnt + ONE;
                    cap_nx = (cnt + ONE) < cap_width;
                end
            end
            GAP: begin
                if (cnt == cap_period - ONE) begin
                    state_nx   = FRAME;
                    en_nx      = 1'b1;
                    cap_nx     = 1'b1;
                    cnt_nx     = '0;
                    smp_nx     = '0;
                    samples_nx = sample_count_o + ONE;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort acts one edge after disarm is sampled and freezes the counters.
        if (abort_q && (state != IDLE)) begin
            state_nx   = IDLE;
            en_nx      = 1'b0;
            cap_nx     = 1'b0;
            active_nx  = 1'b0;
            done_nx    = 1'b0;
            samples_nx = sample_count_o;
            frames_nx  = frame_count_o;
        end

        ttl_nx          = ttl_i;
        ttl_nx[EN_BIT]  = en_nx;
        ttl_nx[CAP_BIT] = cap_nx;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= IDLE;
            cnt            <= '0;
            smp            <= '0;
            abort_q        <= 1'b0;
            ttl_o          <= '0;
            active_o       <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            sample_count_o <= '0;
            frame_count_o  <= '0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            smp            <= smp_nx;
            abort_q        <= disarm_i;
            ttl_o          <= ttl_nx;
            active_o       <= active_nx;
            done_o         <= done_nx;
            err_o          <= err_nx;
            sample_count_o <= samples_nx;
            frame_count_o  <= frames_nx;
        end
    end

    // Configuration is only captured on an accepted arm.
    always_ff @(posedge clk_i) begin
        if (load) begin
            pre_delay   <= pre_delay_i;
            num_samples <= num_samples_i;
            cap_period  <= cap_period_i;
            cap_width   <= cap_width_i;
            repeats     <= repeats_i;
        end
    end

endmodule

// File: doc/pcap_stim_gen.md
# pcap_stim_gen

Parametrised, synthesisable TTL stimulus generator for the panda_top bench and for loopback self-test builds. It drives a bank of TTL input pads with a programmable position-capture pattern:
- an optional pre-delay;
- an enable window containing a train of capture pulses;
- an inter-frame gap;
- a programmable number of frame repeats.

It replaces fixed, hand-sequenced enable/capture stimulus, and adds per-arm counters, abort and configuration-error reporting.

## Interface
Parameters:
- NUM_TTL, 6, number of TTL pads driven.
- EN_BIT, 0, pad index carrying enable; must differ from CAP_BIT.
- CAP_BIT, 2, pad index carrying capture.
- CNT_W, 32, width of all count/config fields.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- arm_i  in  1  start request, sampled each cycle.
- disarm_i  in  1  abort request, sampled each cycle.
- pre_delay_i  in  CNT_W  cycles between arm and first enable.
- num_samples_i  in  CNT_W  capture pulses per frame.
- cap_period_i  in  CNT_W  capture period in cycles.
- cap_width_i  in  CNT_W  capture high time in cycles.
- repeats_i  in  CNT_W  frames per arm; 0 = run until disarm.
- ttl_i  in  NUM_TTL  pass-through values for the non-driven pads.
- ttl_o  out  NUM_TTL  registered pad outputs.
- active_o  out  1  sequence running.
- done_o  out  1  one-cycle pulse on normal completion.
- err_o  out  1  sticky configuration error.
- sample_count_o  out  CNT_W  capture pulses issued since the last valid arm.
- frame_count_o  out  CNT_W  frames completed since the last valid arm.

## Operation
- All outputs are registered; reset value is 0 for every output, including all bits of ttl_o.
- Pads other than EN_BIT and CAP_BIT carry ttl_i delayed by one cycle.
- The config inputs are latched on a valid arm and ignored thereafter until the next return to IDLE.

States and transitions:
- IDLE: enable=0, capture=0.
  - arm_i=1 with an invalid config → err_o=1, stay in IDLE, counters untouched.
  - Invalid config means any of: num_samples_i=0, cap_period_i<2, cap_width_i=0, cap_width_i>=cap_period_i.
  - arm_i=1 with a valid config → clear err_o, sample_count_o and frame_count_o; set active_o; go to DELAY.
- DELAY: counts pre_delay cycles, then → FRAME. With pre_delay=0, DELAY lasts exactly one cycle.
- FRAME:
  - Enable is high for num_samples*cap_period cycles.
  - Capture is high for the first cap_width cycles of each period.
  - sample_count_o increments on each capture rising edge.
  - At frame end, frame_count_o increments. Then:
    - if repeats_i≠0 and frame_count reaches repeats_i → IDLE, with done_o=1 and active_o=0 on the same edge that enable falls;
    - otherwise → GAP.
- GAP: enable=0 for cap_period cycles, then → FRAME.

Boundary rules:
- arm_i while not in IDLE is ignored.
- disarm_i in any non-IDLE state:
  - → IDLE on the next edge, with enable, capture and active_o all 0;
  - done_o is not pulsed;
  - counters hold their values.
- arm_i and disarm_i asserted together: disarm wins. In IDLE the pair is a no-op.
- Counters wrap modulo 2^CNT_W. The period counter is reloaded, never compared with overflow.
- The product num_samples*cap_period is never formed; samples and periods are counted with separate counters.
- Asserting reset_i mid-sequence forces all outputs to 0 immediately (asynchronously).

## Timing
All timing is relative to a valid arm sampled at rising edge k. D = pre_delay, P = cap_period, W = cap_width, N = num_samples.
- active_o rises at edge k+1.
- Enable rises at edge k+1+D.
- Capture pulse i (0-based) rises at k+1+D+i*P and falls at k+1+D+i*P+W.
- Enable falls at k+1+D+N*P.
- The next frame's enable rises at k+1+D+(N+1)*P.
- The final frame's enable falls together with done_o=1 and active_o=0, in the same cycle.
- disarm_i sampled at edge j → outputs low after edge j+1.
- ttl_i → ttl_o latency: 1 cycle.

## Test plan
- Basic run: reset, then arm with D=3, N=4, P=5, W=2, repeats=1.
  - Enable is high for 20 cycles starting 4 edges after arm.
  - Four 2-cycle capture pulses, 5 cycles apart.
  - done_o single pulse coincident with enable fall; sample_count=4, frame_count=1.
- Repeats: N=2, P=3, W=1, repeats=3.
  - Three 6-cycle enable windows separated by 3-cycle gaps.
  - sample_count=6, frame_count=3, exactly one done_o.
- Config errors: arm with W=P=4, then W=0, then P=1.
  - err_o=1 each time, ttl_o stays 0.
  - A following valid arm clears err_o and runs normally.
- Abort: repeats=0, N=8, P=4, W=1; disarm mid-pulse on the 3rd capture.
  - Both pads low one cycle later, no done_o, sample_count=3 held.
  - arm asserted during the run is ignored.
- Pass-through and reset: ttl_i=6'b111111.
  - ttl_o bits 1, 3, 4, 5 follow ttl_i with 1-cycle latency.
  - reset_i mid-FRAME forces ttl_o=0, active_o=0 and counters=0 asynchronously.
- Simultaneous inputs and pre-delay: arm and disarm asserted together in IDLE → no activity. D=0 → enable rises at edge k+1.
